// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, frame FSM and timeout.
// Define PS2_RX_PARITY_CHECK_EN to evaluate odd parity; otherwise the parity bit is consumed unchecked.
module ps2_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_in__clk,
    input  logic       ps2_in__data,
    output logic       ps2_rx__valid,
    output logic [7:0] ps2_rx__data,
    output logic       ps2_rx__parity_error,
    output logic       ps2_rx__framing_error,
    output logic       ps2_rx__timeout
);

    localparam logic [3:0]  FILT_MAX = 4'(FILTER_LEN - 1);
    localparam logic [16:0] TO_MAX   = 17'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_clk_s1, r_clk_s2;
    logic        r_dat_s1, r_dat_s2;
    logic        r_filt_clk;
    logic [3:0]  r_filt_cnt;
    logic        r_fall;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [16:0] r_to_cnt;
    logic        r_valid;
    logic [7:0]  r_data;
    logic        r_ferr;
    logic        r_timeout;
    logic        w_shift;
    logic        w_done;
    logic        w_to_hit;
    logic        w_flip;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_in__clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_in__data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    assign w_flip = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == FILT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= 4'd0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= w_flip && r_filt_clk;
            if (r_clk_s2 == r_filt_clk || w_flip) begin
                r_filt_cnt <= 4'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
            end
            if (w_flip) begin
                r_filt_clk <= ~r_filt_clk;
            end
        end
    end

    assign w_to_hit = (r_state != S_IDLE) && !r_fall && (r_to_cnt == TO_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        if (w_to_hit) begin
            w_state_nxt = S_IDLE;
        end else if (r_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_to_cnt  <= 17'd0;
        end else begin
            if (r_state == S_IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            // LSB arrives first, so each bit enters at the MSB and walks down.
            if (w_shift) begin
                r_shift <= {r_dat_s2, r_shift[7:1]};
            end
            if (r_fall || r_state == S_IDLE || w_to_hit) begin
                r_to_cnt <= 17'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 17'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_data    <= 8'h00;
            r_ferr    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid   <= w_done;
            r_ferr    <= w_done && !r_dat_s2;
            r_timeout <= w_to_hit;
            if (w_done) begin
                r_data <= r_shift;
            end
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    logic r_par;
    logic r_perr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (r_fall && r_state == S_PARITY) begin
                r_par <= r_dat_s2;
            end
            // Good parity means an odd number of ones across data and parity.
            r_perr <= w_done && !(^{r_shift, r_par});
        end
    end

    assign ps2_rx__parity_error = r_perr;
`else
    assign ps2_rx__parity_error = 1'b0;
`endif

    assign ps2_rx__valid         = r_valid;
    assign ps2_rx__data          = r_data;
    assign ps2_rx__framing_error = r_ferr;
    assign ps2_rx__timeout       = r_timeout;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboarded bench for ps2_rx: directed test-plan frames plus random frames against a frame-level model.
module tb_ps2_rx;

    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int HALF = 20;

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct {
        bit         is_to;
        logic [7:0] data;
        bit         perr;
        bit         ferr;
        longint     cyc;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       tmo;

    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;
    evt_t   sb[$];

    ps2_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .ps2_in__clk           (ps2_clk),
        .ps2_in__data          (ps2_data),
        .ps2_rx__valid         (valid),
        .ps2_rx__data          (data),
        .ps2_rx__parity_error  (perr),
        .ps2_rx__framing_error (ferr),
        .ps2_rx__timeout       (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe pops one expected event.
    always @(negedge clk) begin
        if (reset_n) begin
            if (valid && tmo) begin
                chk("valid_timeout_overlap", 1, 0);
            end
            if (valid || tmo) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", {valid, tmo}, 0);
                end else begin
                    evt_t e;
                    e = sb.pop_front();
                    chk("event_kind_timeout", tmo, e.is_to);
                    if (!e.is_to) begin
                        chk("data", data, e.data);
                        chk("parity_error", perr, e.perr);
                        chk("framing_error", ferr, e.ferr);
                        chk("valid_latency", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int nbits, input int glitch_at,
                             input bit push, input evt_t e_in);
        evt_t e;
        e = e_in;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch_at) begin
                tick(5);
                ps2_clk = 1'b0;
                tick(2);
                ps2_clk = 1'b1;
                tick(HALF - 7);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b0;
            if (i == 10 && push) begin
                e.cyc = cyc + FL + 3;
                sb.push_back(e);
            end
            tick(HALF);
            ps2_clk = 1'b1;
        end
        tick(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input int glitch_at);
        evt_t e;
        e.is_to = 1'b0;
        e.data  = b;
        e.perr  = CHECK_EN && (($countones({b, par}) % 2) == 0);
        e.ferr  = !stop;
        e.cyc   = 0;
        send_bits({stop, par, b, 1'b0}, 11, glitch_at, 1'b1, e);
        tick(HALF);
    endtask

    function automatic bit odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    initial begin
        evt_t te;
        te.is_to = 1'b1; te.data = 8'h00; te.perr = 1'b0; te.ferr = 1'b0; te.cyc = 0;

        tick(3);
        @(negedge clk);
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 0);
        chk("reset_perr", perr, 0);
        chk("reset_ferr", ferr, 0);
        chk("reset_timeout", tmo, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(10);

        send_frame(8'h1C, odd_par(8'h1C), 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        send_frame(8'h55, odd_par(8'h55), 1'b0, -1);
        send_frame(8'hAA, odd_par(8'hAA), 1'b1, -1);

        // Partial frame, then silence long enough to abandon it.
        send_bits({1'b1, odd_par(8'h12), 8'h12, 1'b0}, 5, -1, 1'b0, te);
        sb.push_back(te);
        tick(TO + 100);
        send_frame(8'h12, odd_par(8'h12), 1'b1, -1);

        // Short clock glitch and a data-high fall while idle: both ignored.
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(50);
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF);
        send_frame(8'h6B, odd_par(8'h6B), 1'b1, 4);

        // Reset mid-frame discards the partial frame.
        send_bits({1'b1, odd_par(8'h3C), 8'h3C, 1'b0}, 5, -1, 1'b0, te);
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midreset_outputs", {valid, data, perr, ferr, tmo}, 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(20);
        send_frame(8'h3C, odd_par(8'h3C), 1'b1, -1);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            bit par, stop;
            b    = 8'($urandom);
            par  = ($urandom_range(0, 3) == 0) ? !odd_par(b) : odd_par(b);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, par, stop, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1);
        end

        tick(100);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
        $fatal(1, "watchdog expired");
    end

endmodule
